// File: rtl/mem_access.sv
// Purpose: MEM-stage data access unit; turns EX/MEM load/store control into a req/ack bus cycle and aligns load data.
// Latency: minimum 3 cycles per access (IDLE issue, WAIT for ack, DONE release), stallm high for the first 2.
// Backpressure: stallm holds the upstream pipeline while an access is outstanding; TIMEOUT bounds the wait.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   memreadm, memwritem             load / store in MEM stage (store wins if both set)
//   memsizem, memsignedm            access size (0 byte, 1 half, 2/3 word), load sign-extension
//   aluoutm, writedatam             effective byte address, store data
//   dmem_req/we/addr/be/wdata       registered bus request outputs
//   dmem_ack, dmem_rdata            bus completion and read data (sampled only in WAIT)
//   rdm                             aligned/extended load result, registered
//   stallm, misalignm               combinational stall and alignment-fault flags
//   buserrm                         one-cycle registered pulse on access timeout
module mem_access #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        memreadm,
   input  logic        memwritem,
   input  logic [1:0]  memsizem,
   input  logic        memsignedm,
   input  logic [31:0] aluoutm,
   input  logic [31:0] writedatam,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] rdm,
   output logic        stallm,
   output logic        misalignm,
   output logic        buserrm
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       lane_q;
   logic [1:0]       size_q;
   logic             sgn_q;

   logic             access;
   logic             misal_raw;
   logic             issue;
   logic             ack_hit;
   logic             tmo_hit;
   logic [3:0]       be_c;
   logic [31:0]      wdata_c;

   // Narrow sub-word loads: pick the lane, then extend; word loads pass through.
   function automatic logic [31:0] align_load(input logic [31:0] d,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = d[{lane, 3'b000} +: 8];
      h = d[{lane[1], 4'b0000} +: 16];
      case (size)
         2'd0:    r = sgn ? {{24{b[7]}}, b} : {24'h0, b};
         2'd1:    r = sgn ? {{16{h[15]}}, h} : {16'h0, h};
         default: r = d;
      endcase
      return r;
   endfunction

   assign access    = memreadm | memwritem;
   // Size code 3 is reserved and behaves as a word access (memsizem[1] set).
   assign misal_raw = ((memsizem == 2'd1) & aluoutm[0]) |
                      (memsizem[1] & (aluoutm[1:0] != 2'b00));
   assign misalignm = (state == IDLE) & access & misal_raw;
   assign issue     = (state == IDLE) & access & ~misal_raw;
   assign ack_hit   = (state == WAIT) & dmem_ack;
   // Ack beats a coincident timeout.
   assign tmo_hit   = (state == WAIT) & ~dmem_ack & (TIMEOUT != 0) & (cnt == CNT_LAST);

   always_comb begin
      be_c    = 4'b1111;
      wdata_c = writedatam;
      case (memsizem)
         2'd0: begin
            be_c    = 4'b0001 << aluoutm[1:0];
            wdata_c = {4{writedatam[7:0]}};
         end
         2'd1: begin
            be_c    = aluoutm[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{writedatam[15:0]}};
         end
         default: begin
            be_c    = 4'b1111;
            wdata_c = writedatam;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stallm    = 1'b0;
      case (state)
         IDLE: begin
            if (issue) begin
               stallm    = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            stallm = 1'b1;
            if (ack_hit || tmo_hit) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= 32'h0;
         dmem_be    <= 4'h0;
         dmem_wdata <= 32'h0;
         cnt        <= '0;
         lane_q     <= 2'b00;
         size_q     <= 2'b00;
         sgn_q      <= 1'b0;
         buserrm    <= 1'b0;
         rdm        <= 32'h0;
      end else begin
         buserrm <= tmo_hit;
         if (issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= memwritem;
            dmem_addr  <= {aluoutm[31:2], 2'b00};
            dmem_be    <= be_c;
            dmem_wdata <= wdata_c;
            lane_q     <= aluoutm[1:0];
            size_q     <= memsizem;
            sgn_q      <= memsignedm;
            cnt        <= '0;
         end else if (state == WAIT) begin
            cnt <= cnt + 1'b1;
            if (ack_hit || tmo_hit) dmem_req <= 1'b0;
         end
         // Stores leave rdm untouched; a timed-out load returns zero.
         if (ack_hit && !dmem_we)
            rdm <= align_load(dmem_rdata, lane_q, size_q, sgn_q);
         else if (tmo_hit && !dmem_we)
            rdm <= 32'h0;
      end
   end

endmodule
